// File: rtl/la_dump_master.sv
// Read-only bus initiator: dumps COUNT capture-RAM words through the monitor slave
// port (4-phase CARDSEL/SACK_N handshake) and streams them out on dout/valid/ready.
`timescale 1ns/1ps
module la_dump_master #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              CARDSEL,
  output logic              WR_N,
  output logic [ADDR_W-1:0] AI,
  input  logic              SACK_N,
  input  logic [DATA_W-1:0] SLAVE_OUTPUT,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_ACK, S_HOLD, S_RELEASE, S_FIN
  } state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_base, r_ai;
  logic [ADDR_W:0]     r_count, r_idx;
  logic [TW-1:0]       r_tmo;
  logic [DATA_W-1:0]   r_dout;
  logic                r_dout_valid, r_terr;
  logic                w_hs, w_tmo_hit;

  assign w_hs      = r_dout_valid & dout_ready;
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = (count == '0) ? S_FIN : S_REQ;
      S_REQ:      w_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!SACK_N)        w_next = S_HOLD;
        else if (w_tmo_hit) w_next = S_FIN;
      end
      S_HOLD:     if (w_hs) w_next = S_RELEASE;
      // No new request until the slave has released its acknowledge.
      S_RELEASE: begin
        if (SACK_N)         w_next = (r_idx == r_count) ? S_FIN : S_REQ;
        else if (w_tmo_hit) w_next = S_FIN;
      end
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_FIN);
    CARDSEL = (r_state == S_REQ) || (r_state == S_WAIT_ACK);
    WR_N    = 1'b1;
  end

  assign AI          = r_ai;
  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign timeout_err = r_terr;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_base       <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_ai         <= '0;
      r_tmo        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_terr       <= 1'b0;
    end else begin
      // Wait counter restarts on every state entry.
      r_tmo <= (w_next != r_state) ? '0 : r_tmo + TW'(1);
      case (r_state)
        S_IDLE: if (start) begin
          r_base  <= base_addr;
          r_count <= count;
          r_idx   <= '0;
          r_terr  <= 1'b0;
          if (count != '0) r_ai <= base_addr;
        end
        S_WAIT_ACK: begin
          if (!SACK_N) begin
            r_dout       <= SLAVE_OUTPUT;
            r_dout_valid <= 1'b1;
          end else if (w_tmo_hit) begin
            r_terr <= 1'b1;
          end
        end
        S_HOLD: if (w_hs) begin
          r_dout_valid <= 1'b0;
          r_idx        <= r_idx + {{ADDR_W{1'b0}}, 1'b1};
        end
        S_RELEASE: begin
          if (SACK_N && (w_next == S_REQ)) r_ai <= r_base + r_idx[ADDR_W-1:0];
          else if (!SACK_N && w_tmo_hit)   r_terr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_la_dump_master.sv
// Scoreboard bench for la_dump_master: stimulus pushes expected AI/dout values,
// a negedge monitor pops and compares on every request edge and stream handshake.
`timescale 1ns/1ps
module tb_la_dump_master;
  localparam int ADDR_W = 10, DATA_W = 32, TIMEOUT = 16;

  logic              CLK = 1'b0, RST_N = 1'b0, start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic              busy, done, timeout_err, CARDSEL, WR_N;
  logic [ADDR_W-1:0] AI;
  logic              SACK_N = 1'b1;
  logic [DATA_W-1:0] SLAVE_OUTPUT = '0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid, dout_ready = 1'b1;
  logic              slave_en = 1'b1;

  la_dump_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .timeout_err(timeout_err), .CARDSEL(CARDSEL), .WR_N(WR_N),
    .AI(AI), .SACK_N(SACK_N), .SLAVE_OUTPUT(SLAVE_OUTPUT), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 CLK = ~CLK;

  // Slave acks one cycle after CARDSEL, returns 0x1000+addr, releases one cycle after drop.
  always @(posedge CLK) begin
    SACK_N       <= ~(CARDSEL & slave_en);
    SLAVE_OUTPUT <= 32'h1000 + {{(DATA_W-ADDR_W){1'b0}}, AI};
  end

  int checks = 0, passes = 0;
  int n_pop = 0, n_req = 0, done_cnt = 0;
  logic prev_cs = 1'b0;
  logic [31:0] exp_d[$];
  logic [ADDR_W-1:0] exp_a[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (dout_valid && dout_ready) begin
        if (exp_d.size() == 0) begin
          checks++;
          $display("FAIL dout_unexpected: got %0h expected none", dout);
        end else chk("dout", dout, exp_d.pop_front());
        n_pop++;
      end
      if (CARDSEL && !prev_cs) begin
        if (exp_a.size() == 0) begin
          checks++;
          $display("FAIL ai_unexpected: got %0h expected none", AI);
        end else chk("ai", {22'b0, AI}, {22'b0, exp_a.pop_front()});
        n_req++;
      end
      if (done) done_cnt++;
    end
    prev_cs = CARDSEL;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic push_words(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(b + i);
      exp_a.push_back(a);
      exp_d.push_back(32'h1000 + {22'b0, a});
    end
  endtask

  task automatic go(input int b, input int n);
    base_addr = ADDR_W'(b);
    count     = (ADDR_W+1)'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int lim, input string nm);
    for (int i = 0; i < lim && done_cnt == d0; i++) tick();
    chk(nm, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0, r0, p0, hi;
    logic stable, bad_dv;
    logic [31:0] cap;

    // reset state
    tick(); tick();
    chk("rst_cardsel", CARDSEL, 0);
    chk("rst_wr_n", WR_N, 1);
    chk("rst_ai", AI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    RST_N = 1'b1;
    tick();

    // 1: four words from address 0
    push_words(0, 4);
    d0 = done_cnt;
    go(0, 4);
    chk("t1_busy", busy, 1);
    wait_done(d0, 100, "t1_done");
    tick(); tick(); tick();
    chk("t1_done_once", 32'(done_cnt - d0), 1);
    chk("t1_terr", timeout_err, 0);
    chk("t1_idle", busy, 0);
    chk("t1_drained", 32'(exp_d.size() + exp_a.size()), 0);

    // 2: address wrap
    push_words(10'h3FE, 4);
    d0 = done_cnt;
    go(10'h3FE, 4);
    wait_done(d0, 100, "t2_done");
    tick();
    chk("t2_drained", 32'(exp_d.size() + exp_a.size()), 0);

    // 3: count = 0
    d0 = done_cnt; r0 = n_req;
    go(5, 0);
    chk("t3_done_now", done, 1);
    tick();
    chk("t3_done_clr", done, 0);
    chk("t3_busy", busy, 0);
    tick(); tick();
    chk("t3_no_req", 32'(n_req - r0), 0);
    chk("t3_done_once", 32'(done_cnt - d0), 1);

    // 4: consumer stalls 10 cycles on word 1
    push_words(10'h20, 3);
    d0 = done_cnt; p0 = n_pop;
    go(10'h20, 3);
    for (int i = 0; i < 50 && n_pop < p0 + 1; i++) tick();
    chk("t4_word0_seen", 32'(n_pop >= p0 + 1), 1);
    tick();
    dout_ready = 1'b0;
    for (int i = 0; i < 50 && !dout_valid; i++) tick();
    chk("t4_valid", dout_valid, 1);
    cap = dout;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dout !== cap || dout_valid !== 1'b1 || CARDSEL !== 1'b0) stable = 1'b0;
    end
    chk("t4_stable", stable, 1);
    chk("t4_word1", cap, 32'h1021);
    dout_ready = 1'b1;
    wait_done(d0, 100, "t4_done");
    tick();
    chk("t4_drained", 32'(exp_d.size() + exp_a.size()), 0);

    // 5: slave never acks
    slave_en = 1'b0;
    exp_a.push_back(10'h040);
    d0 = done_cnt;
    go(10'h40, 2);
    hi = 0; bad_dv = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (CARDSEL) hi++;
      else if (hi > 0) break;
      if (dout_valid) bad_dv = 1'b1;
      tick();
    end
    chk("t5_cs_len", 32'(hi >= TIMEOUT && hi <= TIMEOUT + 1), 1);
    chk("t5_no_valid", bad_dv, 0);
    wait_done(d0, 5, "t5_done");
    chk("t5_terr", timeout_err, 1);
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_terr_sticky", timeout_err, 1);
    slave_en = 1'b1;
    tick();

    // 6: reset while waiting for ack on word 2
    exp_d.push_back(32'h1010); exp_d.push_back(32'h1011);
    exp_a.push_back(10'h010); exp_a.push_back(10'h011); exp_a.push_back(10'h012);
    p0 = n_pop; r0 = n_req;
    go(10'h10, 4);
    chk("t6_terr_clr", timeout_err, 0);
    for (int i = 0; i < 60 && n_pop < p0 + 2; i++) tick();
    slave_en = 1'b0;
    for (int i = 0; i < 20 && n_req < r0 + 3; i++) tick();
    chk("t6_word2_req", 32'(n_req - r0), 3);
    tick();
    chk("t6_cs_wait", CARDSEL, 1);
    d0 = done_cnt;
    RST_N = 1'b0;
    tick();
    chk("t6_rst_cs", CARDSEL, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_dv", dout_valid, 0);
    RST_N = 1'b1;
    slave_en = 1'b1;
    tick(); tick(); tick();
    chk("t6_no_done", 32'(done_cnt - d0), 0);
    chk("t6_drained", 32'(exp_d.size() + exp_a.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
